// File: rtl/mii_rx_frame_ctrl.sv
// MII receive frame controller: strips preamble/SFD, filters on destination
// address, streams bytes 6.. of accepted frames and reports per-frame status
// plus saturating good/drop counters.
module mii_rx_frame_ctrl #(
    parameter logic [47:0] MAC_ADDR = 48'h123456789abc,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518
) (
    input  logic        eth_rx_clk,
    input  logic        resetn,
    input  logic        eth_rx_dv,
    input  logic [3:0]  eth_rxd,
    input  logic        eth_rxerr,
    input  logic        promisc,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic [10:0] byte_idx,
    output logic        frame_start,
    output logic        frame_end,
    output logic        frame_good,
    output logic [10:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_IDLE = 3'd1,
        S_PRE  = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  nib_q, nib_d;        // previous nibble
    logic        phase_q, phase_d;    // 1 = low nibble already held
    logic [10:0] cnt_q, cnt_d;        // bytes completed, saturating at 2047
    logic        ucast_q, ucast_d;    // dst matches MAC_ADDR so far
    logic        bcast_q, bcast_d;    // dst all-ones so far
    logic        acc_q, acc_d;        // frame accepted and frame_start issued path
    logic        bad_q, bad_d;        // error or oversize seen

    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic [10:0] byte_idx_q, byte_idx_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        frame_good_q, frame_good_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [7:0]  cur_byte;
    logic [10:0] cnt_inc;
    logic [47:0] mac_sh;
    logic        ucast_nx, bcast_nx;
    logic        close, pre_drop, good_nx;

    assign cur_byte = {eth_rxd, nib_q};
    assign cnt_inc  = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
    // Only meaningful for cnt_q < 6: selects the dst byte MSB-first.
    assign mac_sh   = MAC_ADDR >> {3'd5 - cnt_q[2:0], 3'b000};
    assign ucast_nx = ucast_q && (cur_byte == mac_sh[7:0]);
    assign bcast_nx = bcast_q && (cur_byte == 8'hff);
    assign good_nx  = !bad_q && !phase_q && (int'(cnt_q) >= MIN_LEN) && (int'(cnt_q) <= MAX_LEN);

    // Next-state, byte strobes and frame status
    always_comb begin
        state_d       = state_q;
        nib_d         = eth_rxd;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        ucast_d       = ucast_q;
        bcast_d       = bcast_q;
        acc_d         = acc_q;
        bad_d         = bad_q;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        byte_idx_d    = byte_idx_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_good_d  = frame_good_q;
        frame_len_d   = frame_len_q;
        good_cnt_d    = good_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        close         = 1'b0;
        pre_drop      = 1'b0;

        case (state_q)
            S_WAIT: if (!eth_rx_dv) state_d = S_IDLE;
            S_IDLE: begin
                acc_d = 1'b0;
                if (eth_rx_dv) state_d = S_PRE;
            end
            S_PRE: begin
                if (!eth_rx_dv) begin
                    state_d = S_IDLE;
                end else if (eth_rxd == 4'hd && nib_q == 4'h5) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    ucast_d = 1'b1;
                    bcast_d = 1'b1;
                    acc_d   = 1'b0;
                    bad_d   = 1'b0;
                end else if (eth_rxd != 4'h5 && eth_rxd != 4'hd) begin
                    state_d  = S_DROP;
                    pre_drop = 1'b1;
                end
            end
            S_DATA, S_DROP: begin
                if (!eth_rx_dv) begin
                    state_d = S_IDLE;
                    close   = acc_q;
                end else begin
                    // Nibble accounting continues in DROP so frame_len reflects the wire.
                    phase_d = ~phase_q;
                    if (phase_q) cnt_d = cnt_inc;
                    if (state_q == S_DATA) begin
                        if (eth_rxerr) begin
                            state_d = S_DROP;
                            bad_d   = 1'b1;
                        end else if (phase_q) begin
                            if (int'(cnt_inc) > MAX_LEN) begin
                                state_d = S_DROP;
                                bad_d   = 1'b1;
                            end else if (cnt_q < 11'd6) begin
                                ucast_d = ucast_nx;
                                bcast_d = bcast_nx;
                                if (cnt_q == 11'd5) begin
                                    if (ucast_nx || bcast_nx || promisc) acc_d = 1'b1;
                                    else state_d = S_DROP;
                                end
                            end else begin
                                byte_valid_d  = 1'b1;
                                byte_data_d   = cur_byte;
                                byte_idx_d    = cnt_q;
                                frame_start_d = (cnt_q == 11'd6);
                            end
                        end
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (close) begin
            acc_d        = 1'b0;
            frame_end_d  = 1'b1;
            frame_len_d  = cnt_q;
            frame_good_d = good_nx;
            if (good_nx) begin
                if (good_cnt_q != 16'hffff) good_cnt_d = good_cnt_q + 16'd1;
            end else begin
                if (drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
        if (pre_drop && drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // State and output registers
    always_ff @(posedge eth_rx_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_WAIT;
            nib_q         <= '0;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            ucast_q       <= 1'b0;
            bcast_q       <= 1'b0;
            acc_q         <= 1'b0;
            bad_q         <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_idx_q    <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_good_q  <= 1'b0;
            frame_len_q   <= '0;
            good_cnt_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            nib_q         <= nib_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            ucast_q       <= ucast_d;
            bcast_q       <= bcast_d;
            acc_q         <= acc_d;
            bad_q         <= bad_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_idx_q    <= byte_idx_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_good_q  <= frame_good_d;
            frame_len_q   <= frame_len_d;
            good_cnt_q    <= good_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_idx    = byte_idx_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_good  = frame_good_q;
    assign frame_len   = frame_len_q;
    assign good_cnt    = good_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mii_rx_frame_ctrl.sv
// Bench for mii_rx_frame_ctrl: table of frame cases, byte scoreboard,
// and hand sequences for reset-mid-frame and preamble drops.
module tb_mii_rx_frame_ctrl;

    localparam logic [47:0] MAC = 48'h123456789abc;
    localparam int MAXL = 1518;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dv, rxerr, promisc;
    logic [3:0]  rxd;
    logic        byte_valid, frame_start, frame_end, frame_good;
    logic [7:0]  byte_data;
    logic [10:0] byte_idx, frame_len;
    logic [15:0] good_cnt, drop_cnt;

    int npass = 0, ntotal = 0;
    int ends_seen = 0, ends_exp = 0;
    int exp_gc = 0, exp_dc = 0;
    logic [18:0] exp_q[$];

    mii_rx_frame_ctrl #(.MAC_ADDR(MAC), .MIN_LEN(64), .MAX_LEN(MAXL)) dut (
        .eth_rx_clk(clk), .resetn(resetn), .eth_rx_dv(dv), .eth_rxd(rxd),
        .eth_rxerr(rxerr), .promisc(promisc),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_idx(byte_idx),
        .frame_start(frame_start), .frame_end(frame_end), .frame_good(frame_good),
        .frame_len(frame_len), .good_cnt(good_cnt), .drop_cnt(drop_cnt)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [47:0] dst;
        bit          prom;
        int          nbytes;
        bit          extra;
        int          err_at;    // -1: no error
        int          gap;       // dv=0 nibbles after the frame
        bit          exp_acc;
        bit          exp_good;
        int          exp_len;   // -1: not checked
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic nib(input logic [3:0] d, input logic v, input logic e);
        @(negedge clk);
        rxd = d; dv = v; rxerr = e;
    endtask

    function automatic logic [7:0] frame_byte(input logic [47:0] dst, input int i);
        logic [47:0] sh;
        logic [31:0] t;
        if (i < 6) begin
            sh = dst >> (8 * (5 - i));
            return sh[7:0];
        end
        t = i * 37 + 11;
        return t[7:0];
    endfunction

    // Scoreboard: pop an expected {idx,data} per byte_valid
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (frame_end) ends_seen++;
            if (byte_valid) begin
                if (exp_q.size() == 0) chk("byte_unexp", {21'b0, byte_idx}, 32'h7ff);
                else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    chk("byte_idx", {21'b0, byte_idx}, {21'b0, e[18:8]});
                    chk("byte_data", {24'b0, byte_data}, {24'b0, e[7:0]});
                    chk("frame_start", {31'b0, frame_start}, {31'b0, (e[18:8] == 11'd6)});
                end
            end else if (frame_start) begin
                chk("start_stray", {31'b0, frame_start}, 32'h0);
            end
        end
    end

    task automatic send(input vec_t v);
        logic [7:0] b;
        promisc = v.prom;
        for (int k = 0; k < 15; k++) nib(4'h5, 1'b1, 1'b0);
        nib(4'hd, 1'b1, 1'b0);
        for (int i = 0; i < v.nbytes; i++) begin
            b = frame_byte(v.dst, i);
            if (v.exp_acc && i >= 6 && (v.err_at < 0 || i < v.err_at) && i < MAXL)
                exp_q.push_back({11'(i), b});
            nib(b[3:0], 1'b1, (i == v.err_at));
            nib(b[7:4], 1'b1, 1'b0);
        end
        if (v.extra) nib(4'ha, 1'b1, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("frame_end", {31'b0, frame_end}, {31'b0, v.exp_acc});
        if (v.exp_acc) begin
            ends_exp++;
            chk("frame_good", {31'b0, frame_good}, {31'b0, v.exp_good});
            if (v.exp_len >= 0) chk("frame_len", {21'b0, frame_len}, v.exp_len);
            if (v.exp_good) exp_gc++; else exp_dc++;
        end
        chk("good_cnt", {16'b0, good_cnt}, exp_gc);
        chk("drop_cnt", {16'b0, drop_cnt}, exp_dc);
        chk("sb_drained", exp_q.size(), 0);
        for (int g = 1; g < v.gap; g++) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic bad_preamble();
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0);
        nib(4'h3, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0);
        nib(4'hd, 1'b1, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        if (exp_dc < 16'hffff) exp_dc++;
        chk("pre_drop_cnt", {16'b0, drop_cnt}, exp_dc);
    endtask

    vec_t tbl[10];

    initial begin
        logic [7:0] b;
        tbl[0] = '{MAC,              0, 64,   0, -1, 3, 1, 1, 64};
        tbl[1] = '{48'h123456789abd, 0, 64,   0, -1, 3, 0, 0, -1};
        tbl[2] = '{48'h123456789abd, 1, 64,   0, -1, 3, 1, 1, 64};
        tbl[3] = '{48'hffffffffffff, 0, 100,  0, -1, 1, 1, 1, 100}; // back-to-back next
        tbl[4] = '{MAC,              0, 80,   0, 20, 3, 1, 0, -1};
        tbl[5] = '{MAC,              0, 63,   0, -1, 3, 1, 0, 63};
        tbl[6] = '{MAC,              0, 1519, 0, -1, 3, 1, 0, -1};
        tbl[7] = '{MAC,              0, 64,   1, -1, 3, 1, 0, 64};
        tbl[8] = '{MAC,              0, 1518, 0, -1, 3, 1, 1, 1518};
        tbl[9] = '{48'h123456789abc, 0, 70,   0, -1, 3, 1, 1, 70};

        resetn = 1'b0; dv = 1'b0; rxd = 4'h0; rxerr = 1'b0; promisc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", {31'b0, byte_valid}, 32'h0);
        chk("rst_frame_end", {31'b0, frame_end}, 32'h0);
        chk("rst_frame_good", {31'b0, frame_good}, 32'h0);
        chk("rst_frame_len", {21'b0, frame_len}, 32'h0);
        chk("rst_good_cnt", {16'b0, good_cnt}, 32'h0);
        chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'h0);

        // Frame already running when reset releases: must stay silent
        for (int k = 0; k < 15; k++) nib(4'h5, 1'b1, 1'b0);
        nib(4'hd, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i == 10) resetn = 1'b1;
            b = frame_byte(MAC, i);
            nib(b[3:0], 1'b1, 1'b0);
            nib(b[7:4], 1'b1, 1'b0);
        end
        nib(4'h0, 1'b0, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        nib(4'h0, 1'b0, 1'b0);
        chk("rstmid_frame_end", {31'b0, frame_end}, 32'h0);
        chk("rstmid_good_cnt", {16'b0, good_cnt}, 32'h0);
        chk("rstmid_drop_cnt", {16'b0, drop_cnt}, 32'h0);

        for (int t = 0; t < 10; t++) send(tbl[t]);

        bad_preamble();

        // Preload drop_cnt just under saturation
        @(negedge clk);
        force dut.drop_cnt_q = 16'hfffd;
        @(posedge clk); #1;
        release dut.drop_cnt_q;
        exp_dc = 16'hfffd;
        @(negedge clk);
        chk("preload_drop_cnt", {16'b0, drop_cnt}, exp_dc);
        for (int r = 0; r < 3; r++) bad_preamble();
        chk("sat_drop_cnt", {16'b0, drop_cnt}, 32'hffff);

        repeat (4) @(negedge clk);
        chk("frame_end_total", ends_seen, ends_exp);
        chk("sb_final", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
